// File: rtl/instruction_compressor_pkg.sv
// Shared definitions for the instruction compressor: FSM states, default
// marker/opcode sizing and the constants used to build compressed tokens.
package instruction_compressor_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ENCODE_LEN = 4;
  localparam logic [DEF_ENCODE_LEN-1:0] DEF_OPCODE = 4'b1111;
  localparam int unsigned DEF_ENTRIES    = 16;

  // Table index sits this many bits up inside the token payload.
  localparam int unsigned TOKEN_IDX_SHIFT = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_compressor_pair_table.sv
// Instruction-pair table: ENTRIES registered {first, second} pairs with valid
// bits, a single write port, a global clear and a combinational lookup that
// reports the lowest-index valid entry equal to {lk_first, lk_second}.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears valid bits)
//   we, widx, wr_first/second  write one entry and mark it valid
//   clr                   clear all valid bits (wins over we)
//   lk_first/second       lookup key
//   hit_c, idx_c          combinational match flag and lowest matching index
module instruction_compressor_pair_table #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [WIDTH-1:0] wr_first,
  input  logic [WIDTH-1:0] wr_second,
  input  logic             clr,
  input  logic [WIDTH-1:0] lk_first,
  input  logic [WIDTH-1:0] lk_second,
  output logic             hit_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]   first_q  [ENTRIES];
  logic [WIDTH-1:0]   first_d  [ENTRIES];
  logic [WIDTH-1:0]   second_q [ENTRIES];
  logic [WIDTH-1:0]   second_d [ENTRIES];

  // Write / clear next-state; clear has priority.
  always_comb begin
    valid_d  = valid_q;
    first_d  = first_q;
    second_d = second_q;
    if (clr) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[widx]  = 1'b1;
      first_d[widx]  = wr_first;
      second_d[widx] = wr_second;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        first_q[i]  <= '0;
        second_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      first_q  <= first_d;
      second_q <= second_d;
    end
  end

  // Priority match: scan high to low so the lowest matching index wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (first_q[i] == lk_first) && (second_q[i] == lk_second)) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/instruction_compressor.sv
// Instruction compressor: replaces adjacent instruction pairs found in a
// programmable table with a single token word {OPCODE, index<<3}, passing
// all other instructions through unchanged. One instruction is held while
// waiting for a possible partner; in_last flushes it.
// Ports:
//   clk, reset                   clock, async active-low reset
//   in_valid/in_ready/in_instr   input stream handshake and word
//   in_brk                       word is a branch target (never a pair second)
//   in_last                      final word of stream, forces drain
//   out_valid/out_ready/out_word registered output slot
//   tbl_we/tbl_idx/tbl_first/tbl_second/tbl_clr  pair-table programming
//   err_opcode                   sticky: an input word carried the marker
module instruction_compressor
  import instruction_compressor_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ENCODE_LEN = DEF_ENCODE_LEN,
  parameter logic [ENCODE_LEN-1:0] OPCODE = ENCODE_LEN'(DEF_OPCODE),
  parameter int unsigned ENTRIES    = DEF_ENTRIES,
  localparam int unsigned IDX_W     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             in_brk,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [WIDTH-1:0] tbl_first,
  input  logic [WIDTH-1:0] tbl_second,
  input  logic             tbl_clr,
  output logic             err_opcode
);

  localparam int unsigned PAYLOAD_W = WIDTH - ENCODE_LEN;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic             slot_free_c;
  logic             in_xfer_c;
  logic [WIDTH-1:0] token_c;

  // Lookup key is the held word followed by the incoming word.
  instruction_compressor_pair_table #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) u_pair_table (
    .clk       (clk),
    .rst_n     (reset),
    .we        (tbl_we),
    .widx      (tbl_idx),
    .wr_first  (tbl_first),
    .wr_second (tbl_second),
    .clr       (tbl_clr),
    .lk_first  (held_q),
    .lk_second (in_instr),
    .hit_c     (hit_c),
    .idx_c     (idx_c)
  );

  // Slot can take a new word if empty or being consumed this cycle.
  assign slot_free_c = !out_valid_q || out_ready;
  assign in_ready    = (state_q != ST_DRAIN) && ((state_q == ST_EMPTY) || slot_free_c);
  assign in_xfer_c   = in_valid && in_ready;
  assign token_c     = {OPCODE, PAYLOAD_W'(idx_c) << TOKEN_IDX_SHIFT};

  // Next-state, held word, output slot and error flag.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = err_q;

    if (in_xfer_c && (in_instr[WIDTH-1 -: ENCODE_LEN] == OPCODE)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          held_d  = in_instr;
          state_d = in_last ? ST_DRAIN : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (in_xfer_c) begin
          out_valid_d = 1'b1;
          if (!in_brk && hit_c) begin
            out_word_d = token_c;
            state_d    = ST_EMPTY;
          end else begin
            out_word_d = held_q;
            held_d     = in_instr;
            state_d    = in_last ? ST_DRAIN : ST_HOLD;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_free_c) begin
          out_valid_d = 1'b1;
          out_word_d  = held_q;
          state_d     = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      held_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign err_opcode = err_q;

endmodule

// File: tb/tb_instruction_compressor.sv
// Bench for instruction_compressor: directed vectors, a stream-level model of
// the expected output sequence, and literal checks on captured outputs.
module tb_instruction_compressor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_brk, in_last;
  logic [31:0] in_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_word;
  logic        tbl_we, tbl_clr;
  logic [3:0]  tbl_idx;
  logic [31:0] tbl_first, tbl_second;
  logic        err_opcode;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state
  bit          m_held, m_drain, m_err;
  logic [31:0] m_hv;
  bit          m_tv [16];
  logic [31:0] m_tf [16];
  logic [31:0] m_ts [16];
  logic [31:0] exp_q [$];
  logic [31:0] got [$];
  bit          prev_v, prev_rdy;
  logic [31:0] prev_w;

  instruction_compressor dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_brk     (in_brk),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .tbl_we     (tbl_we),
    .tbl_idx    (tbl_idx),
    .tbl_first  (tbl_first),
    .tbl_second (tbl_second),
    .tbl_clr    (tbl_clr),
    .err_opcode (err_opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 16; i++)
      if (m_tv[i] && m_tf[i] == a && m_ts[i] == b) return i;
    return -1;
  endfunction

  // Compare process: check against model state, then advance the model with
  // what the coming rising edge will do.
  always @(negedge clk) begin
    if (!reset) begin
      m_held = 0; m_drain = 0; m_err = 0;
      for (int i = 0; i < 16; i++) m_tv[i] = 0;
      exp_q.delete();
      prev_v = 0;
    end else begin
      if (prev_v && !prev_rdy) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_word", out_word, prev_w);
      end
      if (out_valid && out_ready) begin
        got.push_back(out_word);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out: got %h expected no word", out_word);
        end else begin
          chk("out_word", out_word, exp_q.pop_front());
        end
      end
      chk("in_ready", 32'(in_ready), 32'(!m_drain && (!m_held || !out_valid || out_ready)));
      chk("err_opcode", 32'(err_opcode), 32'(m_err));

      if (m_drain && (!out_valid || out_ready)) begin
        exp_q.push_back(m_hv);
        m_held = 0; m_drain = 0;
      end

      if (in_valid && in_ready) begin
        int idx;
        if (in_instr[31:28] == 4'hF) m_err = 1;
        if (!m_held) begin
          m_held = 1; m_hv = in_instr; m_drain = in_last;
        end else begin
          idx = in_brk ? -1 : m_lookup(m_hv, in_instr);
          if (idx >= 0) begin
            exp_q.push_back(32'hF000_0000 | 32'(idx * 8));
            m_held = 0;
          end else begin
            exp_q.push_back(m_hv);
            m_hv = in_instr; m_drain = in_last;
          end
        end
      end

      if (tbl_clr) begin
        for (int i = 0; i < 16; i++) m_tv[i] = 0;
      end else if (tbl_we) begin
        m_tv[tbl_idx] = 1; m_tf[tbl_idx] = tbl_first; m_ts[tbl_idx] = tbl_second;
      end

      prev_v = out_valid; prev_rdy = out_ready; prev_w = out_word;
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic b, input logic l);
    int n = 0;
    in_valid = 1; in_instr = w; in_brk = b; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck low for word %h", w);
    end
    @(posedge clk); #1;
    in_valid = 0; in_brk = 0; in_last = 0;
  endtask

  task automatic tbl_write(input logic [3:0] i, input logic [31:0] a, input logic [31:0] b);
    tbl_we = 1; tbl_idx = i; tbl_first = a; tbl_second = b;
    @(posedge clk); #1;
    tbl_we = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    idle(2);
    reset = 1;
  endtask

  task automatic chk_got(input string name, input logic [31:0] w [$]);
    chk({name, "_count"}, 32'(got.size()), 32'(w.size()));
    for (int i = 0; i < w.size(); i++)
      chk(name, (i < got.size()) ? got[i] : 32'hDEAD_DEAD, w[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; in_valid = 0; in_instr = 0; in_brk = 0; in_last = 0;
    out_ready = 1; tbl_we = 0; tbl_clr = 0; tbl_idx = 0; tbl_first = 0; tbl_second = 0;

    // Reset values
    idle(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_err", 32'(err_opcode), 32'd0);
    reset = 1;
    idle(1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Pair compressed to token
    tbl_write(4'd3, 32'h00A0_0093, 32'h00B0_0113);
    got.delete();
    send(32'h00A0_0093, 0, 0);
    send(32'h00B0_0113, 0, 0);
    chk("token_latency", 32'(out_valid), 32'd1);
    idle(3);
    chk_got("token", '{32'hF000_0018});

    // Branch target breaks the pair
    got.delete();
    send(32'h00A0_0093, 0, 0);
    send(32'h00B0_0113, 1, 1);
    idle(4);
    chk_got("brk", '{32'h00A0_0093, 32'h00B0_0113});

    // Single last word drains
    got.delete();
    send(32'h1111_1111, 0, 1);
    chk("drain_ready_low", 32'(in_ready), 32'd0);
    idle(1);
    chk("drain_ready_back", 32'(in_ready), 32'd1);
    idle(2);
    chk_got("drain", '{32'h1111_1111});

    // Lowest matching index wins
    tbl_write(4'd5, 32'h0000_0055, 32'h0000_0066);
    tbl_write(4'd1, 32'h0000_0055, 32'h0000_0066);
    got.delete();
    send(32'h0000_0055, 0, 0);
    send(32'h0000_0066, 0, 0);
    idle(3);
    chk_got("prio", '{32'hF000_0008});

    // Clear wins over same-cycle write; old entries gone
    tbl_clr = 1; tbl_we = 1; tbl_idx = 4'd2; tbl_first = 32'h77; tbl_second = 32'h88;
    idle(1);
    tbl_clr = 0; tbl_we = 0;
    got.delete();
    send(32'h0000_0077, 0, 0);
    send(32'h0000_0088, 0, 1);
    send(32'h00A0_0093, 0, 0);
    send(32'h00B0_0113, 0, 1);
    idle(4);
    chk_got("clr", '{32'h77, 32'h88, 32'h00A0_0093, 32'h00B0_0113});

    // Lookup sees table contents before a same-cycle write
    got.delete();
    send(32'h0000_0099, 0, 0);
    tbl_we = 1; tbl_idx = 4'd0; tbl_first = 32'h99; tbl_second = 32'hAA;
    send(32'h0000_00AA, 0, 1);
    tbl_we = 0;
    idle(4);
    send(32'h0000_0099, 0, 0);
    send(32'h0000_00AA, 0, 1);
    idle(3);
    chk_got("wr_order", '{32'h99, 32'hAA, 32'hF000_0000});

    // Output stall for 5 cycles
    got.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h1000_0000 + 32'(i) * 32'h111, 0, i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    idle(6);
    chk_got("stall", '{32'h1000_0000, 32'h1000_0111, 32'h1000_0222, 32'h1000_0333,
                       32'h1000_0444, 32'h1000_0555, 32'h1000_0666, 32'h1000_0777});

    // Marker in input: sticky error, word passed through, reset clears
    got.delete();
    send(32'hF000_0000, 0, 1);
    idle(3);
    chk("err_set", 32'(err_opcode), 32'd1);
    send(32'h1234_5678, 0, 1);
    idle(3);
    chk("err_sticky", 32'(err_opcode), 32'd1);
    chk_got("err", '{32'hF000_0000, 32'h1234_5678});
    apply_reset();
    chk("err_cleared", 32'(err_opcode), 32'd0);

    // Reset in HOLD with a pending output word
    tbl_write(4'd3, 32'h00A0_0093, 32'h00B0_0113);
    send(32'h2222_2222, 0, 0);
    send(32'h3333_3333, 0, 0);
    out_ready = 0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_word", out_word, 32'd0);
    idle(2);
    reset = 1;
    out_ready = 1;
    idle(1);
    got.delete();
    send(32'h00A0_0093, 0, 0);
    send(32'h00B0_0113, 0, 1);
    idle(4);
    chk_got("post_rst", '{32'h00A0_0093, 32'h00B0_0113});

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
